// File: rtl/sm_stream_out.sv
// sm_stream_out
// Collects the Sorter's element writes into a register array, then, on the
// rising edge of sort_done, streams the elements out in ascending address
// order over a valid/ready handshake. Sticky flags report missing,
// duplicate and late writes; they never influence the data path.
module sm_stream_out #(
  parameter int DATA_WIDTH       = 32,
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        SM_valid,
  input  logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
  input  logic [DATA_WIDTH-1:0]       SM_data,
  input  logic                        sort_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [LOG2_ELEMENT_NUM-1:0] out_index,
  output logic                        out_last,
  output logic                        stream_done,
  output logic                        err_missing,
  output logic                        err_dup,
  output logic                        err_late
);

  localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_IDX = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_STREAM,
    ST_FINISH
  } state_t;

  state_t                      state_reg;
  logic [DATA_WIDTH-1:0]       mem_reg [ELEMENT_NUM];
  logic [ELEMENT_NUM-1:0]      written_reg;
  logic [LOG2_ELEMENT_NUM-1:0] rd_idx_reg;
  logic                        done_prev_reg;
  logic                        out_valid_reg;
  logic                        stream_done_reg;
  logic                        err_missing_reg;
  logic                        err_dup_reg;
  logic                        err_late_reg;

  logic [ELEMENT_NUM-1:0]      wr_onehot;
  logic                        done_edge;
  logic                        collect_wr;
  logic                        xfer;

  // One-hot decode of the current write address, used both to update the
  // written bitmap and to let a write coincident with the done edge count
  // toward completeness.
  genvar gi;
  generate
    for (gi = 0; gi < ELEMENT_NUM; gi++) begin : g_onehot
      assign wr_onehot[gi] = SM_valid && (SM_addr == LOG2_ELEMENT_NUM'(gi));
    end
  endgenerate

  // done_prev_reg resets to 1 so a level already high out of reset is not an edge.
  assign done_edge  = sort_done && !done_prev_reg;
  assign collect_wr = (state_reg == ST_COLLECT) && SM_valid;
  assign xfer       = out_valid_reg && out_ready;

  // Element storage: only written while collecting; last write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ELEMENT_NUM; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (collect_wr) begin
      mem_reg[SM_addr] <= SM_data;
    end
  end

  // Control FSM: collect writes, stream on the done edge, then idle until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_COLLECT;
      written_reg     <= '0;
      rd_idx_reg      <= '0;
      done_prev_reg   <= 1'b1;
      out_valid_reg   <= 1'b0;
      stream_done_reg <= 1'b0;
      err_missing_reg <= 1'b0;
      err_dup_reg     <= 1'b0;
      err_late_reg    <= 1'b0;
    end else begin
      done_prev_reg <= sort_done;

      if (SM_valid && (state_reg != ST_COLLECT)) begin
        err_late_reg <= 1'b1;
      end

      case (state_reg)
        ST_COLLECT: begin
          if (SM_valid) begin
            written_reg <= written_reg | wr_onehot;
            if (written_reg[SM_addr]) begin
              err_dup_reg <= 1'b1;
            end
          end
          if (done_edge) begin
            state_reg     <= ST_STREAM;
            out_valid_reg <= 1'b1;
            if (~&(written_reg | wr_onehot)) begin
              err_missing_reg <= 1'b1;
            end
          end
        end

        ST_STREAM: begin
          if (xfer) begin
            if (rd_idx_reg == LAST_IDX) begin
              state_reg       <= ST_FINISH;
              out_valid_reg   <= 1'b0;
              stream_done_reg <= 1'b1;
            end else begin
              rd_idx_reg <= rd_idx_reg + LOG2_ELEMENT_NUM'(1);
            end
          end
        end

        ST_FINISH: begin
          // Idle until reset; late writes are flagged above.
        end

        default: begin
          state_reg <= ST_COLLECT;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = mem_reg[rd_idx_reg];
  assign out_index   = rd_idx_reg;
  assign out_last    = out_valid_reg && (rd_idx_reg == LAST_IDX);
  assign stream_done = stream_done_reg;
  assign err_missing = err_missing_reg;
  assign err_dup     = err_dup_reg;
  assign err_late    = err_late_reg;

endmodule
